// File: rtl/apb_bus_arbiter_pkg.sv
// Shared types and widths for the two-requester APB bus arbiter.
package apb_bus_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } apb_state_e;

endpackage

// File: rtl/apb_bus_arbiter_if.sv
// APB bus bundle between the arbiter (master) and the peripheral slaves.
interface apb_bus_arbiter_if
  import apb_bus_arbiter_pkg::*;
#(
  parameter int NUM_SLAVES = 4
) ();

  logic [ADDR_W-1:0]            PADDR;
  logic [DATA_W-1:0]            PWDATA;
  logic                         PWRITE;
  logic [NUM_SLAVES-1:0]        PSEL;
  logic                         PENABLE;
  logic [DATA_W*NUM_SLAVES-1:0] PRDATA;
  logic [NUM_SLAVES-1:0]        PREADY;
  logic [NUM_SLAVES-1:0]        PSLVERR;

  modport master (
    output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb_bus_arbiter_addr_decoder.sv
// Combinational peripheral-window decode: address -> hit, one-hot select, slave index.
module apb_addr_decoder
  import apb_bus_arbiter_pkg::*;
#(
  parameter int                NUM_SLAVES = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h1000_0000,
  parameter int                DEC_LSB    = 12,
  localparam int               IDX_W      = $clog2(NUM_SLAVES)
) (
  input  logic [ADDR_W-1:0]     addr,
  output logic                  hit,
  output logic [NUM_SLAVES-1:0] sel,
  output logic [IDX_W-1:0]      idx
);

  localparam int TAG_LSB = DEC_LSB + IDX_W;

  // Byte offset within a slave's page plays no part in the decode.
  logic unused_offset;
  assign unused_offset = ^addr[DEC_LSB-1:0];

  assign idx = addr[DEC_LSB +: IDX_W];
  assign hit = (addr[ADDR_W-1:TAG_LSB] == BASE_ADDR[ADDR_W-1:TAG_LSB]);

  always_comb begin
    sel      = '0;
    sel[idx] = hit;
  end

endmodule

// File: rtl/apb_bus_arbiter.sv
// Two-requester APB master: round-robin arbitration, address decode, SETUP/ACCESS
// sequencing with timeout, and registered per-requester completion status.
module apb_bus_arbiter
  import apb_bus_arbiter_pkg::*;
#(
  parameter int                NUM_SLAVES = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h1000_0000,
  parameter int                DEC_LSB    = 12,
  parameter int                TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              transfer0,
  input  logic              write0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ready0,
  output logic [DATA_W-1:0] rdata0,
  output logic              err0,
  input  logic              transfer1,
  input  logic              write1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ready1,
  output logic [DATA_W-1:0] rdata1,
  output logic              err1,
  apb_bus_arbiter_if.master apb
);

  localparam int IDX_W = $clog2(NUM_SLAVES);
  localparam int TC_W  = $clog2(TIMEOUT + 1);

  apb_state_e            state_q, state_d;
  logic                  grant_q, grant_d, rr_q;
  logic                  req_any;
  logic [ADDR_W-1:0]     req_addr, paddr_q;
  logic [DATA_W-1:0]     req_wdata, pwdata_q;
  logic                  req_write, pwrite_q;
  logic                  dec_hit;
  logic [NUM_SLAVES-1:0] dec_sel, psel_q;
  logic [IDX_W-1:0]      dec_idx, idx_q;
  logic [TC_W-1:0]       tcount_q;
  logic [DATA_W-1:0]     prdata_sel;
  logic                  pready_sel, pslverr_sel, timed_out;
  logic                  done_fire, done_who, done_err;
  logic [DATA_W-1:0]     done_data;

  // rr_q names the requester that wins a tie; a lone requester always wins.
  assign req_any   = transfer0 || transfer1;
  assign grant_d   = (transfer0 && transfer1) ? rr_q : transfer1;
  assign req_addr  = grant_d ? addr1  : addr0;
  assign req_wdata = grant_d ? wdata1 : wdata0;
  assign req_write = grant_d ? write1 : write0;

  apb_addr_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .BASE_ADDR  (BASE_ADDR),
    .DEC_LSB    (DEC_LSB)
  ) u_decoder (
    .addr (req_addr),
    .hit  (dec_hit),
    .sel  (dec_sel),
    .idx  (dec_idx)
  );

  assign pready_sel  = apb.PREADY[idx_q];
  assign pslverr_sel = apb.PSLVERR[idx_q];
  assign timed_out   = (tcount_q == TC_W'(TIMEOUT - 1));

  always_comb begin
    prdata_sel = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (idx_q == IDX_W'(k)) prdata_sel = apb.PRDATA[k*DATA_W +: DATA_W];
    end
  end

  // Next state plus the completion record that DONE will present to the granted requester.
  always_comb begin
    state_d   = state_q;
    done_fire = 1'b0;
    done_who  = grant_q;
    done_data = '0;
    done_err  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_any) begin
          done_who = grant_d;
          if (dec_hit) begin
            state_d = SETUP;
          end else begin
            state_d   = DONE;
            done_fire = 1'b1;
            done_err  = 1'b1;
          end
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (pready_sel) begin
          state_d   = DONE;
          done_fire = 1'b1;
          done_data = pwrite_q ? '0 : prdata_sel;
          done_err  = pslverr_sel;
        end else if (timed_out) begin
          state_d   = DONE;
          done_fire = 1'b1;
          done_err  = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Bus request latch, timeout counter, round-robin pointer and requester status.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_q  <= 1'b0;
      rr_q     <= 1'b0;
      idx_q    <= '0;
      psel_q   <= '0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      tcount_q <= '0;
      ready0   <= 1'b0;
      rdata0   <= '0;
      err0     <= 1'b0;
      ready1   <= 1'b0;
      rdata1   <= '0;
      err1     <= 1'b0;
    end else begin
      if (state_q == IDLE && req_any) begin
        grant_q  <= grant_d;
        idx_q    <= dec_idx;
        psel_q   <= dec_sel;
        paddr_q  <= req_addr;
        pwdata_q <= req_wdata;
        pwrite_q <= req_write;
        tcount_q <= '0;
      end
      if (state_q == ACCESS) tcount_q <= tcount_q + TC_W'(1);
      if (state_q == DONE)   rr_q     <= ~grant_q;

      ready0 <= done_fire && !done_who;
      ready1 <= done_fire &&  done_who;
      if (done_fire && !done_who) begin
        rdata0 <= done_data;
        err0   <= done_err;
      end
      if (done_fire && done_who) begin
        rdata1 <= done_data;
        err1   <= done_err;
      end
    end
  end

  assign apb.PADDR   = paddr_q;
  assign apb.PWDATA  = pwdata_q;
  assign apb.PWRITE  = pwrite_q;
  assign apb.PSEL    = (state_q == SETUP || state_q == ACCESS) ? psel_q : '0;
  assign apb.PENABLE = (state_q == ACCESS);

endmodule

// File: tb/tb_apb_bus_arbiter.sv
// Directed self-checking bench for apb_bus_arbiter with hand-computed expectations.
module tb_apb_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        transfer0, write0, transfer1, write1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        ready0, ready1, err0, err1;
  logic [31:0] rdata0, rdata1;
  int          n_cmp  = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  apb_bus_arbiter_if #(.NUM_SLAVES(4)) apb ();

  apb_bus_arbiter #(
    .NUM_SLAVES (4),
    .BASE_ADDR  (32'h1000_0000),
    .DEC_LSB    (12),
    .TIMEOUT    (255)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .transfer0 (transfer0),
    .write0    (write0),
    .addr0     (addr0),
    .wdata0    (wdata0),
    .ready0    (ready0),
    .rdata0    (rdata0),
    .err0      (err0),
    .transfer1 (transfer1),
    .write1    (write1),
    .addr1     (addr1),
    .wdata1    (wdata1),
    .ready1    (ready1),
    .rdata1    (rdata1),
    .err1      (err1),
    .apb       (apb)
  );

  // All driving and sampling happens on the falling edge; each negedge is one cycle.
  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    transfer0 = 0; write0 = 0; addr0 = '0; wdata0 = '0;
    transfer1 = 0; write1 = 0; addr1 = '0; wdata1 = '0;
    apb.PRDATA = '0; apb.PREADY = 4'hF; apb.PSLVERR = '0;
    do_reset();
    n_cmp++; if ({ready0, ready1, err0, err1} !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_flags: got %b want 0000", {ready0, ready1, err0, err1}); end
    n_cmp++; if ({rdata0, rdata1} !== 64'h0) begin n_fail++; $display("[TB] FAIL reset_rdata: got %h want 0", {rdata0, rdata1}); end
    n_cmp++; if ({apb.PSEL, apb.PENABLE, apb.PWRITE} !== 6'b0) begin n_fail++; $display("[TB] FAIL reset_bus_ctrl: got %b want 000000", {apb.PSEL, apb.PENABLE, apb.PWRITE}); end
    n_cmp++; if ({apb.PADDR, apb.PWDATA} !== 64'h0) begin n_fail++; $display("[TB] FAIL reset_bus_data: got %h want 0", {apb.PADDR, apb.PWDATA}); end
  endtask

  task automatic test_read_zero_wait();
    apb.PREADY = 4'hF; apb.PSLVERR = '0; apb.PRDATA[32 +: 32] = 32'hDEAD_BEEF;
    transfer0 = 1; write0 = 0; addr0 = 32'h1000_1004;
    @(negedge clk);
    n_cmp++; if (apb.PSEL !== 4'b0010 || apb.PENABLE !== 1'b0) begin n_fail++; $display("[TB] FAIL read_setup: got psel=%b pen=%b want 0010/0", apb.PSEL, apb.PENABLE); end
    n_cmp++; if (apb.PADDR !== 32'h1000_1004) begin n_fail++; $display("[TB] FAIL read_paddr: got %h want 10001004", apb.PADDR); end
    n_cmp++; if (ready0 !== 1'b0) begin n_fail++; $display("[TB] FAIL read_early_ready_c1: got %b want 0", ready0); end
    @(negedge clk);
    n_cmp++; if (apb.PSEL !== 4'b0010 || apb.PENABLE !== 1'b1) begin n_fail++; $display("[TB] FAIL read_access: got psel=%b pen=%b want 0010/1", apb.PSEL, apb.PENABLE); end
    n_cmp++; if (ready0 !== 1'b0) begin n_fail++; $display("[TB] FAIL read_early_ready_c2: got %b want 0", ready0); end
    @(negedge clk);
    n_cmp++; if (ready0 !== 1'b1 || ready1 !== 1'b0) begin n_fail++; $display("[TB] FAIL read_ready_c3: got r0=%b r1=%b want 1/0", ready0, ready1); end
    n_cmp++; if (rdata0 !== 32'hDEAD_BEEF || err0 !== 1'b0) begin n_fail++; $display("[TB] FAIL read_data: got %h err=%b want deadbeef/0", rdata0, err0); end
    n_cmp++; if (apb.PSEL !== 4'b0000 || apb.PENABLE !== 1'b0) begin n_fail++; $display("[TB] FAIL read_done_bus: got psel=%b pen=%b want 0000/0", apb.PSEL, apb.PENABLE); end
    transfer0 = 0;
    @(negedge clk);
    n_cmp++; if (ready0 !== 1'b0 || rdata0 !== 32'hDEAD_BEEF) begin n_fail++; $display("[TB] FAIL read_hold: got r0=%b rdata=%h want 0/deadbeef", ready0, rdata0); end
  endtask

  task automatic test_write_wait_states();
    apb.PREADY = 4'h0;
    transfer0 = 1; write0 = 1; addr0 = 32'h1000_3000; wdata0 = 32'h0000_55AA;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      n_cmp++; if (apb.PSEL !== 4'b1000 || apb.PWDATA !== 32'h55AA || apb.PWRITE !== 1'b1) begin n_fail++; $display("[TB] FAIL write_bus_c%0d: got psel=%b pwdata=%h pwrite=%b want 1000/55aa/1", c, apb.PSEL, apb.PWDATA, apb.PWRITE); end
      n_cmp++; if (apb.PENABLE !== (c >= 2) || ready0 !== 1'b0) begin n_fail++; $display("[TB] FAIL write_phase_c%0d: got pen=%b r0=%b want %b/0", c, apb.PENABLE, ready0, c >= 2); end
      if (c == 5) apb.PREADY = 4'b1000;
    end
    @(negedge clk);
    n_cmp++; if (ready0 !== 1'b1 || err0 !== 1'b0 || rdata0 !== 32'h0) begin n_fail++; $display("[TB] FAIL write_done_c6: got r0=%b err=%b rdata=%h want 1/0/0", ready0, err0, rdata0); end
    transfer0 = 0; write0 = 0; apb.PREADY = 4'hF;
    @(negedge clk);
  endtask

  task automatic test_slave_error();
    apb.PREADY = 4'hF; apb.PSLVERR = 4'b0100; apb.PRDATA[64 +: 32] = 32'h2222_0002;
    transfer0 = 1; write0 = 0; addr0 = 32'h1000_2000;
    repeat (3) @(negedge clk);
    n_cmp++; if (ready0 !== 1'b1 || err0 !== 1'b1 || rdata0 !== 32'h2222_0002) begin n_fail++; $display("[TB] FAIL slverr: got r0=%b err=%b rdata=%h want 1/1/22220002", ready0, err0, rdata0); end
    transfer0 = 0;
    @(negedge clk);
    apb.PSLVERR = '0;
  endtask

  task automatic test_contention();
    int t0 = 0, t1 = 0, n = 0;
    logic both = 1'b0;
    logic seq[4];
    do_reset();
    apb.PREADY = 4'hF; apb.PRDATA[0 +: 32] = 32'h1111_0000; apb.PRDATA[64 +: 32] = 32'h2222_0002;
    transfer0 = 1; write0 = 0; addr0 = 32'h1000_0000;
    transfer1 = 1; write1 = 0; addr1 = 32'h1000_2008;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (ready0 && ready1) both = 1'b1;
      if (ready0) begin t0 = c; transfer0 = 0; end
      if (ready1) begin t1 = c; transfer1 = 0; end
      if (t0 != 0 && t1 != 0) break;
    end
    n_cmp++; if (t0 != 3 || t1 != 7) begin n_fail++; $display("[TB] FAIL contention_order: got ready0@%0d ready1@%0d want 3/7", t0, t1); end
    n_cmp++; if (rdata0 !== 32'h1111_0000 || rdata1 !== 32'h2222_0002) begin n_fail++; $display("[TB] FAIL contention_data: got %h/%h want 11110000/22220002", rdata0, rdata1); end
    @(negedge clk);
    transfer0 = 1; transfer1 = 1;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(negedge clk);
      if (ready0 && ready1) both = 1'b1;
      if (ready0) begin seq[n] = 1'b0; n++; end
      else if (ready1) begin seq[n] = 1'b1; n++; end
    end
    transfer0 = 0; transfer1 = 0;
    n_cmp++; if (n != 4) begin n_fail++; $display("[TB] FAIL held_count: got %0d grants want 4", n); end
    for (int i = 0; i < n; i++) begin
      n_cmp++; if (seq[i] !== i[0]) begin n_fail++; $display("[TB] FAIL held_grant%0d: got req%0d want req%0d", i, seq[i], i[0]); end
    end
    n_cmp++; if (both !== 1'b0) begin n_fail++; $display("[TB] FAIL dual_ready: got %b want 0", both); end
    @(negedge clk);
  endtask

  task automatic test_decode_miss();
    transfer1 = 1; write1 = 0; addr1 = 32'h2000_0000;
    @(negedge clk);
    n_cmp++; if (ready1 !== 1'b1 || err1 !== 1'b1 || rdata1 !== 32'h0) begin n_fail++; $display("[TB] FAIL miss_done_c1: got r1=%b err=%b rdata=%h want 1/1/0", ready1, err1, rdata1); end
    n_cmp++; if (apb.PSEL !== 4'b0000 || ready0 !== 1'b0) begin n_fail++; $display("[TB] FAIL miss_bus_c1: got psel=%b r0=%b want 0000/0", apb.PSEL, ready0); end
    transfer1 = 0;
    @(negedge clk);
    n_cmp++; if (ready1 !== 1'b0 || err1 !== 1'b1 || apb.PSEL !== 4'b0000) begin n_fail++; $display("[TB] FAIL miss_after: got r1=%b err=%b psel=%b want 0/1/0000", ready1, err1, apb.PSEL); end
  endtask

  task automatic test_timeout();
    int t = 0;
    apb.PREADY = 4'h0;
    transfer0 = 1; write0 = 0; addr0 = 32'h1000_1000;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (ready0) begin t = c; break; end
    end
    n_cmp++; if (t != 257) begin n_fail++; $display("[TB] FAIL timeout_cycle: got %0d want 257", t); end
    n_cmp++; if (err0 !== 1'b1 || rdata0 !== 32'h0) begin n_fail++; $display("[TB] FAIL timeout_status: got err=%b rdata=%h want 1/0", err0, rdata0); end
    transfer0 = 0; apb.PREADY = 4'hF;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_access();
    logic seen = 1'b0;
    apb.PREADY = 4'h0; apb.PRDATA[32 +: 32] = 32'hDEAD_BEEF;
    transfer0 = 1; write0 = 0; addr0 = 32'h1000_1004;
    repeat (2) @(negedge clk);
    n_cmp++; if (apb.PENABLE !== 1'b1) begin n_fail++; $display("[TB] FAIL abort_in_access: got pen=%b want 1", apb.PENABLE); end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (apb.PSEL !== 4'b0000 || apb.PENABLE !== 1'b0 || ready0 !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_bus: got psel=%b pen=%b r0=%b want 0000/0/0", apb.PSEL, apb.PENABLE, ready0); end
    reset = 1'b0; transfer0 = 0; apb.PREADY = 4'hF;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (ready0 || ready1) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_no_ready: got %b want 0", seen); end
    transfer0 = 1;
    repeat (3) @(negedge clk);
    n_cmp++; if (ready0 !== 1'b1 || rdata0 !== 32'hDEAD_BEEF) begin n_fail++; $display("[TB] FAIL abort_recover: got r0=%b rdata=%h want 1/deadbeef", ready0, rdata0); end
    transfer0 = 0;
    @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got no end of run want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_read_zero_wait();
    test_write_wait_states();
    test_slave_error();
    test_contention();
    test_decode_miss();
    test_timeout();
    test_reset_mid_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
